// File: rtl/qdr2_arb_pkg.sv
// Shared types and default sizes for the QDR-II SRAM port arbiter.
package qdr2_arb_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } qdr2_arb_st_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 19;
    localparam int DEF_DATA_W    = 144;
    localparam int DEF_TAG_DEPTH = 16;
    localparam int STAT_W        = 32;
    localparam int OCC_W         = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/qdr2_arb_rr.sv
// Round-robin picker: searches req starting at ptr, returns a one-hot grant
// and the pointer just past the winner (unchanged when nothing wins).
module qdr2_arb_rr #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt_ptr
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr  = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/qdr2_sram_arbiter.sv
// Shares one QDR-II user port among NUM_REQ clients: independent RR write/read
// arbitration, in-order tag FIFO steering read data back. QDR2_ARB_STATS_EN adds grant counters.
module qdr2_sram_arbiter
    import qdr2_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_ready,
    input  logic [NUM_REQ-1:0]             wr_valid,
    output logic [NUM_REQ-1:0]             wr_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wr_data,
    input  logic [NUM_REQ-1:0]             rd_valid,
    output logic [NUM_REQ-1:0]             rd_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           mem_wr_valid,
    output logic [ADDR_W-1:0]              mem_wr_addr,
    output logic [DATA_W-1:0]              mem_wr_data,
    output logic                           mem_rd_valid,
    output logic [ADDR_W-1:0]              mem_rd_addr,
    input  logic                           mem_rd_data_valid,
    input  logic [DATA_W-1:0]              mem_rd_data,
    output logic                           err_orphan
`ifdef QDR2_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0] stat_wr_cnt,
    output logic [NUM_REQ-1:0][STAT_W-1:0] stat_rd_cnt,
    output logic [OCC_W-1:0]               stat_max_occ
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TAG_AW = $clog2(TAG_DEPTH);
    localparam int PTR_W  = TAG_AW + 1;

    qdr2_arb_st_t st, st_nxt;
    logic         grant_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= ST_INIT;
        else       st <= st_nxt;
    end

    // mem_ready also gates the current cycle so a grant never lands on a
    // controller that has just dropped ready.
    always_comb begin
        st_nxt   = st;
        grant_en = 1'b0;
        case (st)
            ST_INIT: if (mem_ready) st_nxt = ST_RUN;
            ST_RUN: begin
                grant_en = mem_ready;
                if (!mem_ready) st_nxt = ST_HOLD;
            end
            ST_HOLD: if (mem_ready) st_nxt = ST_RUN;
            default: st_nxt = ST_INIT;
        endcase
    end

    logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] tag_wptr, tag_rptr;
    logic             tag_full, tag_empty, tag_push, tag_pop, orphan;
    logic [IDX_W-1:0] tag_head;

    assign tag_empty = (tag_wptr == tag_rptr);
    assign tag_full  = (tag_wptr[TAG_AW] != tag_rptr[TAG_AW]) &&
                       (tag_wptr[TAG_AW-1:0] == tag_rptr[TAG_AW-1:0]);
    assign tag_head  = tag_mem[tag_rptr[TAG_AW-1:0]];
    assign tag_pop   = mem_rd_data_valid && !tag_empty;
    assign orphan    = mem_rd_data_valid && tag_empty;

    logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
    logic [IDX_W-1:0]   wp, rp, wp_nxt, rp_nxt;

    qdr2_arb_rr #(.N(NUM_REQ), .PW(IDX_W)) u_wr_rr (
        .req(wr_valid), .ptr(wp), .en(grant_en), .gnt(wr_gnt), .nxt_ptr(wp_nxt)
    );

    qdr2_arb_rr #(.N(NUM_REQ), .PW(IDX_W)) u_rd_rr (
        .req(rd_valid), .ptr(rp), .en(grant_en && !tag_full), .gnt(rd_gnt), .nxt_ptr(rp_nxt)
    );

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;
    assign tag_push = |rd_gnt;

    logic [ADDR_W-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_W-1:0] wr_sel_data;
    logic [IDX_W-1:0]  rd_idx;

    // Grants are one-hot, so an AND-OR mux is enough.
    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        rd_sel_addr = '0;
        rd_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_sel_addr |= wr_addr[i] & {ADDR_W{wr_gnt[i]}};
            wr_sel_data |= wr_data[i] & {DATA_W{wr_gnt[i]}};
            rd_sel_addr |= rd_addr[i] & {ADDR_W{rd_gnt[i]}};
            if (rd_gnt[i]) rd_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            wp           <= '0;
        end else begin
            mem_wr_valid <= |wr_gnt;
            if (|wr_gnt) begin
                mem_wr_addr <= wr_sel_addr;
                mem_wr_data <= wr_sel_data;
                wp          <= wp_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_valid <= 1'b0;
            mem_rd_addr  <= '0;
            rp           <= '0;
            tag_wptr     <= '0;
        end else begin
            mem_rd_valid <= tag_push;
            if (tag_push) begin
                mem_rd_addr <= rd_sel_addr;
                rp          <= rp_nxt;
                tag_wptr    <= tag_wptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wptr[TAG_AW-1:0]] <= rd_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_rptr   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid  <= tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
            err_orphan <= err_orphan | orphan;
            if (tag_pop) begin
                rsp_data <= mem_rd_data;
                tag_rptr <= tag_rptr + PTR_W'(1);
            end
        end
    end

`ifdef QDR2_ARB_STATS_EN
    logic [PTR_W-1:0] tag_occ;
    assign tag_occ = tag_wptr - tag_rptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stat_wr_cnt[g] <= '0;
                stat_rd_cnt[g] <= '0;
            end else begin
                if (wr_gnt[g]) stat_wr_cnt[g] <= sat_inc(stat_wr_cnt[g]);
                if (rd_gnt[g]) stat_rd_cnt[g] <= sat_inc(stat_rd_cnt[g]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             stat_max_occ <= '0;
        else if (OCC_W'(tag_occ) > stat_max_occ) stat_max_occ <= OCC_W'(tag_occ);
    end
`endif

endmodule
